// File: rtl/pulse_counter.sv
// Wrapping pulse counter with a load port, a one-shot stop mode, a carry
// pulse on wrap and a saturating count of carry pulses.
module pulse_counter #(
    parameter int unsigned P_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wenable,
    input  logic [P_BIT-1:0] wcount,
    input  logic             oneshot,
    input  logic             carry_clr,
    output logic [P_BIT-1:0] count,
    output logic             carry,
    output logic             done,
    output logic [15:0]      carry_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam logic [P_BIT-1:0] MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic advance;
    logic wrap;

    // A load pre-empts counting; a finished one-shot ignores enable.
    assign advance = !wenable && enable && !done;
    assign wrap    = advance && (count == MAX);

    // Counter value, wrap pulse and sticky one-shot completion flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else if (wenable) begin
            count <= wcount;
            carry <= 1'b0;
            done  <= 1'b0;
        end else if (wrap) begin
            count <= '0;
            carry <= 1'b1;
            if (oneshot) begin
                done <= 1'b1;
            end
        end else if (advance) begin
            count <= count + P_BIT'(1);
            carry <= 1'b0;
        end else begin
            carry <= 1'b0;
        end
    end

    // Saturating carry counter; a clear coinciding with a wrap counts that wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_cnt <= '0;
        end else if (carry_clr) begin
            carry_cnt <= wrap ? CNT_W'(1) : '0;
        end else if (wrap && (carry_cnt != CNT_SAT)) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pulse_counter.sv
// Scoreboard bench for pulse_counter: a P_BIT=4 instance for the main
// behaviour and a P_BIT=1 instance for the back-to-back wrap case.
module tb_pulse_counter;

    typedef struct {
        int          id;
        logic [3:0]  count;
        logic        carry;
        logic        done;
        logic [15:0] cc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, en0 = 1'b0, we0 = 1'b0, os0 = 1'b0, clr0 = 1'b0;
    logic [3:0]  wc0  = 4'd0;
    logic [3:0]  cnt0;
    logic        cy0, dn0;
    logic [15:0] cc0;

    logic        rst1 = 1'b1, en1 = 1'b0, we1 = 1'b0, os1 = 1'b0, clr1 = 1'b0;
    logic [0:0]  wc1  = 1'b0;
    logic [0:0]  cnt1;
    logic        cy1, dn1;
    logic [15:0] cc1;

    pulse_counter #(.P_BIT(4)) dut0 (
        .clk(clk), .reset(rst0), .enable(en0), .wenable(we0), .wcount(wc0),
        .oneshot(os0), .carry_clr(clr0), .count(cnt0), .carry(cy0),
        .done(dn0), .carry_cnt(cc0)
    );

    pulse_counter #(.P_BIT(1)) dut1 (
        .clk(clk), .reset(rst1), .enable(en1), .wenable(we1), .wcount(wc1),
        .oneshot(os1), .carry_clr(clr1), .count(cnt1), .carry(cy1),
        .done(dn1), .carry_cnt(cc1)
    );

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_push = 0;

    // Drive one edge's inputs on the falling edge and queue the expected result.
    task automatic step(input int sel, input logic rst, input logic we,
                        input logic en, input logic os, input logic clr,
                        input logic [3:0] wc, input logic [3:0] ec,
                        input logic ecy, input logic edn, input logic [15:0] ecc);
        exp_t e;
        @(negedge clk);
        e.id = n_push; e.count = ec; e.carry = ecy; e.done = edn; e.cc = ecc;
        n_push++;
        if (sel == 0) begin
            rst0 = rst; we0 = we; en0 = en; os0 = os; clr0 = clr; wc0 = wc;
            q0.push_back(e);
        end else begin
            rst1 = rst; we1 = we; en1 = en; os1 = os; clr1 = clr; wc1 = wc[0];
            q1.push_back(e);
        end
    endtask

    // Monitor for the 4-bit instance.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                n_vec++;
                if (cnt0 !== e.count || cy0 !== e.carry || dn0 !== e.done || cc0 !== e.cc) begin
                    n_err++;
                    $display("FAIL p4 vec %0d: got count=%0d carry=%0b done=%0b carry_cnt=%h, expected count=%0d carry=%0b done=%0b carry_cnt=%h",
                             e.id, cnt0, cy0, dn0, cc0, e.count, e.carry, e.done, e.cc);
                end
            end
        end
    end

    // Monitor for the 1-bit instance.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                n_vec++;
                if ({3'b000, cnt1} !== e.count || cy1 !== e.carry || dn1 !== e.done || cc1 !== e.cc) begin
                    n_err++;
                    $display("FAIL p1 vec %0d: got count=%0d carry=%0b done=%0b carry_cnt=%h, expected count=%0d carry=%0b done=%0b carry_cnt=%h",
                             e.id, cnt1, cy1, dn1, cc1, e.count, e.carry, e.done, e.cc);
                end
            end
        end
    end

    // Directed stimulus: sel, rst, we, en, os, clr, wc -> count, carry, done, carry_cnt.
    initial begin
        int budget;
        // reset state
        step(0, 1,0,0,0,0, 4'd0,  4'd0, 0,0, 16'd0);
        // periodic run: 1..15 then wrap
        for (int i = 1; i <= 15; i++)
            step(0, 0,0,1,0,0, 4'd0, 4'(i), 0,0, 16'd0);
        step(0, 0,0,1,0,0, 4'd0,  4'd0, 1,0, 16'd1);
        step(0, 0,0,0,0,0, 4'd0,  4'd0, 0,0, 16'd1);
        // load 14 with enable high, then wrap
        step(0, 0,1,1,0,0, 4'd14, 4'd14,0,0, 16'd1);
        step(0, 0,0,1,0,0, 4'd0,  4'd15,0,0, 16'd1);
        step(0, 0,0,1,0,0, 4'd0,  4'd0, 1,0, 16'd2);
        // one-shot from 13
        step(0, 0,1,1,1,0, 4'd13, 4'd13,0,0, 16'd2);
        step(0, 0,0,1,1,0, 4'd0,  4'd14,0,0, 16'd2);
        step(0, 0,0,1,1,0, 4'd0,  4'd15,0,0, 16'd2);
        step(0, 0,0,1,1,0, 4'd0,  4'd0, 1,1, 16'd3);
        for (int i = 0; i < 5; i++)
            step(0, 0,0,1,1,0, 4'd0, 4'd0, 0,1, 16'd3);
        step(0, 0,1,1,1,0, 4'd3,  4'd3, 0,0, 16'd3);
        // load of zero never pulses carry
        step(0, 0,1,0,0,0, 4'd0,  4'd0, 0,0, 16'd3);
        // enable gap at MAX
        step(0, 0,1,0,0,0, 4'd15, 4'd15,0,0, 16'd3);
        for (int i = 0; i < 3; i++)
            step(0, 0,0,0,0,0, 4'd0, 4'd15, 0,0, 16'd3);
        step(0, 0,0,1,0,0, 4'd0,  4'd0, 1,0, 16'd4);
        // carry_clr without a wrap
        step(0, 0,0,0,0,1, 4'd0,  4'd0, 0,0, 16'd0);
        // oneshot dropped before the wrap: no done
        step(0, 0,1,0,1,0, 4'd14, 4'd14,0,0, 16'd0);
        step(0, 0,0,1,1,0, 4'd0,  4'd15,0,0, 16'd0);
        step(0, 0,0,1,0,0, 4'd0,  4'd0, 1,0, 16'd1);
        step(0, 0,0,1,0,0, 4'd0,  4'd1, 0,0, 16'd1);
        // carry_clr on a wrap edge counts that wrap
        step(0, 0,1,0,0,0, 4'd15, 4'd15,0,0, 16'd1);
        step(0, 0,0,1,0,0, 4'd0,  4'd0, 1,0, 16'd2);
        step(0, 0,1,0,0,0, 4'd15, 4'd15,0,0, 16'd2);
        step(0, 0,0,1,0,1, 4'd0,  4'd0, 1,0, 16'd1);
        // reset beats load and enable at count 9
        step(0, 0,1,0,0,0, 4'd9,  4'd9, 0,0, 16'd1);
        step(0, 1,1,1,0,1, 4'd5,  4'd0, 0,0, 16'd0);
        step(0, 0,0,1,0,0, 4'd0,  4'd1, 0,0, 16'd0);
        // reset while done is set
        step(0, 0,1,0,1,0, 4'd15, 4'd15,0,0, 16'd0);
        step(0, 0,0,1,1,0, 4'd0,  4'd0, 1,1, 16'd1);
        step(0, 1,0,1,1,0, 4'd0,  4'd0, 0,0, 16'd0);
        step(0, 0,0,1,0,0, 4'd0,  4'd1, 0,0, 16'd0);
        // reset on the carry-high cycle
        step(0, 0,1,0,0,0, 4'd15, 4'd15,0,0, 16'd0);
        step(0, 0,0,1,0,0, 4'd0,  4'd0, 1,0, 16'd1);
        step(0, 1,0,1,0,0, 4'd0,  4'd0, 0,0, 16'd0);
        // saturation: preset carry_cnt near the top, then two wraps
        step(0, 0,1,0,0,0, 4'd15, 4'd15,0,0, 16'hFFFE);
        force dut0.carry_cnt = 16'hFFFE;
        #1;
        release dut0.carry_cnt;
        step(0, 0,0,1,0,0, 4'd0,  4'd0, 1,0, 16'hFFFF);
        step(0, 0,1,0,0,0, 4'd15, 4'd15,0,0, 16'hFFFF);
        step(0, 0,0,1,0,0, 4'd0,  4'd0, 1,0, 16'hFFFF);
        step(0, 0,0,1,0,1, 4'd0,  4'd1, 0,0, 16'd0);
        step(0, 0,0,0,0,0, 4'd0,  4'd1, 0,0, 16'd0);

        // P_BIT=1 with enable held: carry every second cycle
        step(1, 1,0,0,0,0, 4'd0,  4'd0, 0,0, 16'd0);
        step(1, 0,0,1,0,0, 4'd0,  4'd1, 0,0, 16'd0);
        step(1, 0,0,1,0,0, 4'd0,  4'd0, 1,0, 16'd1);
        step(1, 0,0,1,0,0, 4'd0,  4'd1, 0,0, 16'd1);
        step(1, 0,0,1,0,0, 4'd0,  4'd0, 1,0, 16'd2);
        step(1, 0,0,1,0,0, 4'd0,  4'd1, 0,0, 16'd2);
        step(1, 0,0,1,0,0, 4'd0,  4'd0, 1,0, 16'd3);
        step(1, 0,1,1,0,0, 4'd0,  4'd0, 0,0, 16'd3);
        step(1, 0,0,0,0,0, 4'd0,  4'd0, 0,0, 16'd3);

        budget = 20;
        while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(negedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the stimulus never completes.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pulse_counter.md
PULSE_COUNTER -- requirements
Module: pulse_counter

Interface
REQ-001 Parameter: P_BIT, default 4, counter width in bits; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  count-advance request, sampled each posedge.
REQ-005 wenable  input  1  load strobe for wcount.
REQ-006 wcount  input  P_BIT  load value.
REQ-007 oneshot  input  1  0 = periodic (free-running wrap), 1 = one-shot (stop after first wrap); sampled each cycle.
REQ-008 carry_clr  input  1  clears carry_cnt.
REQ-009 count  output  P_BIT  current counter value, registered.
REQ-010 carry  output  1  single-cycle wrap pulse, registered.
REQ-011 done  output  1  one-shot completion flag, registered, sticky.
REQ-012 carry_cnt  output  16  saturating count of carry pulses, registered.

Function
REQ-013 MAX = 2^P_BIT - 1; count arithmetic is modulo 2^P_BIT.
REQ-014 Priority per edge: reset > wenable > enable > hold.
REQ-015 wenable=1: count <= wcount, done <= 0, carry <= 0; enable is ignored that cycle.
REQ-016 wenable=0, enable=1, done=0, count<MAX: count <= count+1, carry <= 0.
REQ-017 wenable=0, enable=1, done=0, count==MAX: count <= 0, carry <= 1 (wrap event).
REQ-018 Wrap event with oneshot=1: done <= 1 on the same edge that sets carry.
REQ-019 done=1: count holds, carry <= 0, enable ignored; only wenable or reset clears done.
REQ-020 enable=0 (no load): count and done hold, carry <= 0.
REQ-021 carry is high for exactly one cycle per wrap and is never high on two consecutive cycles, for every P_BIT >= 1, including P_BIT=1 with enable held high (carry every 2nd cycle).
REQ-022 carry is high only in the cycle in which count == 0 as the result of a wrap; loads never assert carry, including a load of 0.
REQ-023 carry_cnt increments on the same edge that sets carry; it saturates at 16'hFFFF and never wraps.
REQ-024 carry_clr=1 without a wrap: carry_cnt <= 0; carry_clr=1 on a wrap edge: carry_cnt <= 1.
REQ-025 Changing oneshot mid-count takes effect at the next wrap only; it never sets or clears done directly.
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 reset=1 at a posedge: count=0, carry=0, done=0, carry_cnt=0; this overrides wenable, enable and carry_clr.
REQ-028 reset mid-operation (including a carry-high cycle or done=1): all outputs take reset values on that edge; counting resumes from 0 on the first enabled edge after reset deasserts.

Verification (P_BIT=4 unless stated)
REQ-029 Periodic run: reset, oneshot=0, enable=1 for 16 edges -> count 1..15, then 0 with carry=1 for one cycle; carry_cnt=1.
REQ-030 Load with enable=1: wcount=14, wenable=1 -> count=14, carry=0; 2 enabled edges -> 15, then 0 with carry=1.
REQ-031 One-shot run: load 13, oneshot=1, enable=1 -> 14, 15, 0 with carry=1 and done=1; 5 more enabled edges -> count=0, carry=0, done=1, carry_cnt unchanged; then load 3 -> done=0, count=3.
REQ-032 Enable gap at MAX: count=15, enable=0 for 3 cycles -> count=15, carry=0; enable=1 -> count=0, carry=1.
REQ-033 Reset at count=9 with wenable=1 and enable=1 -> all outputs zero on the next edge.
REQ-034 carry_cnt at 16'hFFFF with a wrap -> stays 16'hFFFF; carry_clr on a wrap edge -> carry_cnt=1. Separately, with P_BIT=1 and enable held high, carry toggles 0,1,0,1 and is never high on consecutive cycles.
